err_flit_arbiter: RTL and testbench

//  Clocked arbiter/scheduler in front of the shared 9-bit error-detect path.

---
 rtl/err_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/err_flit_arbiter.sv | 147 ++++++++++++++
 tb/tb_err_flit_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/err_arb_pkg.sv
// Shared types and helpers for the error-flit arbiter.
//   state_t  : arbiter FSM states (IDLE, SEND, NACK)
//   RETRY_W  : width of the per-port retry counters
//   retry_t  : per-port retry count type
//   wrap_inc : index + 1 modulo n, used for round-robin pointer advance
package err_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, NACK = 2'd2} state_t;

  localparam int RETRY_W = 4;
  typedef logic [RETRY_W-1:0] retry_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per port
//   ptr        : highest-priority port index; search runs ptr, ptr+1, ... mod NP
//   gnt_onehot : one-hot grant (zero when nothing requests)
//   gnt_idx    : index of the granted port (0 when nothing requests)
//   any        : at least one request present
module rr_picker #(
  parameter int NP = 4
) (
  input  logic [NP-1:0]         req,
  input  logic [$clog2(NP)-1:0] ptr,
  output logic [NP-1:0]         gnt_onehot,
  output logic [$clog2(NP)-1:0] gnt_idx,
  output logic                  any
);
  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int i = 0; i < NP; i++) begin
      idx = (int'(ptr) + i) % NP;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = $clog2(NP)'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/err_flit_arbiter.sv
// Round-robin arbiter in front of the shared error-detect path.
// A granted flit with a clean error flag is held on out_* until accepted;
// an errored flit is NACKed for one cycle and its port keeps priority so the
// retry wins the next arbitration. After MAX_RETRY NACKs the flit is dropped.
// Ports:
//   CLK, _RESET           clock, synchronous active-low reset
//   in_valid/in_ready     per-port handshake (in_ready one-hot or zero, IDLE only)
//   in_data/in_err        per-port flit (port p at [p*W +: W]) and error flag
//   out_valid/out_ready   clean flit handshake; out_data/out_src held until accepted
//   nack_valid/nack_port  one-cycle NACK pulse and port
//   drop                  one-cycle pulse with the final NACK of a dropped flit
//   err_cnt               saturating per-port error counts (port p at [p*CW +: CW])
// Build option: define ERR_CNT_EN to implement err_cnt; otherwise it is tied to 0.
module err_flit_arbiter
  import err_arb_pkg::*;
#(
  parameter int NP        = 4,
  parameter int W         = 9,
  parameter int MAX_RETRY = 3,
  parameter int CW        = 8
) (
  input  logic                  CLK,
  input  logic                  _RESET,
  input  logic [NP-1:0]         in_valid,
  output logic [NP-1:0]         in_ready,
  input  logic [NP*W-1:0]       in_data,
  input  logic [NP-1:0]         in_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [$clog2(NP)-1:0] out_src,
  output logic                  nack_valid,
  output logic [$clog2(NP)-1:0] nack_port,
  output logic                  drop,
  output logic [NP*CW-1:0]      err_cnt
);
  localparam int IW = $clog2(NP);

  state_t                   state_q, state_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]            g_q, g_d;
  logic [W-1:0]             data_q, data_d;
  logic                     drop_q, drop_d;
  logic [NP-1:0][RETRY_W-1:0] retry_q, retry_d;

  logic [NP-1:0] gnt_onehot;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [IW-1:0] g_next;

  rr_picker #(.NP(NP)) u_pick (
    .req        (in_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign g_next     = IW'(wrap_inc(int'(g_q), NP));
  assign in_ready   = (state_q == IDLE) ? gnt_onehot : '0;
  assign out_valid  = (state_q == SEND);
  assign out_data   = data_q;
  assign out_src    = g_q;
  assign nack_valid = (state_q == NACK);
  assign nack_port  = g_q;
  assign drop       = drop_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    data_d   = data_q;
    drop_d   = 1'b0;
    retry_d  = retry_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          g_d    = gnt_idx;
          data_d = in_data[gnt_idx*W +: W];
          if (in_err[gnt_idx]) begin
            state_d = NACK;
            // Decide at accept time whether this NACK is the last one, so the
            // drop pulse is a plain flop aligned with nack_valid.
            drop_d  = ((retry_q[gnt_idx] + 1'b1) == RETRY_W'(MAX_RETRY));
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          retry_d[g_q] = '0;
          rr_ptr_d     = g_next;
          state_d      = IDLE;
        end
      end
      NACK: begin
        state_d = IDLE;
        if (drop_q) begin
          retry_d[g_q] = '0;
          rr_ptr_d     = g_next;
        end else begin
          retry_d[g_q] = retry_q[g_q] + 1'b1;
          rr_ptr_d     = g_q;  // sticky: retry gets first pick
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      data_q   <= '0;
      drop_q   <= 1'b0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      retry_q  <= retry_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [NP-1:0][CW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == NACK && err_cnt_q[g_q] != {CW{1'b1}})
      err_cnt_d[g_q] = err_cnt_q[g_q] + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_err_flit_arbiter.sv
module tb_err_flit_arbiter;
  localparam int NP = 4, W = 9, MAX_RETRY = 3, CW = 2;

  logic              CLK = 1'b0;
  logic              _RESET;
  logic [NP-1:0]     in_valid, in_ready, in_err;
  logic [NP*W-1:0]   in_data;
  logic              out_valid, out_ready;
  logic [W-1:0]      out_data;
  logic [1:0]        out_src, nack_port;
  logic              nack_valid, drop;
  logic [NP*CW-1:0]  err_cnt;

  always #5 CLK = ~CLK;

  err_flit_arbiter #(.NP(NP), .W(W), .MAX_RETRY(MAX_RETRY), .CW(CW)) dut (
    .CLK(CLK), ._RESET(_RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .nack_valid(nack_valid), .nack_port(nack_port), .drop(drop), .err_cnt(err_cnt)
  );

  typedef struct packed { logic [W-1:0] data; logic err; } flit_s;
  typedef struct { int kind; int port; int data; int drp; } ev_t;  // kind 0=out, 1=nack

  flit_s src_q[NP][$];
  ev_t   sb[$];
  int    total = 0, bad = 0;
  int    pend_kind = 0;  // outcome expected in the cycle after an accept

  function automatic logic [W-1:0] dv(int p, int n);
    return W'(p * 64 + n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic add(input int p, input int n, input logic e);
    flit_s f;
    f.data = dv(p, n);
    f.err  = e;
    src_q[p].push_back(f);
  endtask

  task automatic exp_out(input int p, input int n);
    ev_t e;
    e.kind = 0; e.port = p; e.data = int'(dv(p, n)); e.drp = 0;
    sb.push_back(e);
  endtask

  task automatic exp_nack(input int p, input int d);
    ev_t e;
    e.kind = 1; e.port = p; e.data = 0; e.drp = d;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      in_valid[p]        = (src_q[p].size() > 0);
      in_data[p*W +: W]  = in_valid[p] ? src_q[p][0].data : '0;
      in_err[p]          = in_valid[p] ? src_q[p][0].err : 1'b0;
    end
  endtask

  function automatic bit srcs_busy();
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pop_cmp(input int kind, input int port, input int data, input int drp);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_kind", kind, 32'hFFFF);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_port", port, e.port);
    if (kind == 0) chk("ev_data", data, e.data);
    else           chk("ev_drop", drp, e.drp);
  endtask

  // One cycle: sample mid-cycle, score events, then update sources after the edge.
  task automatic step();
    logic [NP-1:0] acc;
    @(negedge CLK);
    if (pend_kind != 0) begin
      chk("lat_out", out_valid, pend_kind == 1);
      chk("lat_nack", nack_valid, pend_kind == 2);
    end
    pend_kind = 0;
    if (out_valid || nack_valid) chk("ir_busy", in_ready, 0);
    chk("ir_1hot", $countones(in_ready) <= 1, 1);
    if (out_valid && out_ready) pop_cmp(0, out_src, out_data, 0);
    if (nack_valid) pop_cmp(1, nack_port, 0, drop);
    else if (drop)  chk("drop_no_nack", drop, 0);
    acc = in_ready & in_valid;
    for (int p = 0; p < NP; p++) if (acc[p]) pend_kind = src_q[p][0].err ? 2 : 1;
    @(posedge CLK); #1;
    for (int p = 0; p < NP; p++) if (acc[p]) void'(src_q[p].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input string tag);
    int n = 0;
    while ((sb.size() > 0 || srcs_busy()) && n < 200) begin step(); n++; end
    chk({tag, "_timeout"}, n < 200, 1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    sb.delete();
    drive();
    _RESET = 1'b0;
    @(posedge CLK); #1;
    _RESET = 1'b1;
    pend_kind = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_nack", nack_valid, 0);
    chk("rst_drop", drop, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_cnt", err_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_sat, exp_two;
`ifdef ERR_CNT_EN
    exp_sat = 3; exp_two = 2;
`else
    exp_sat = 0; exp_two = 0;
`endif
    _RESET = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_err = '0; in_data = '0;
    #1;
    do_reset();
    chk("rst_in_ready", in_ready, 0);

    // 1: reset while a flit is held in SEND, then grant order restarts at 0
    out_ready = 1'b0;
    add(2, 0, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("t1_send", out_valid, 1);
    step();
    do_reset();

    // 2: all ports valid and clean -> 0,1,2,3 then wrap to 0
    out_ready = 1'b1;
    add(0, 1, 1'b0); add(1, 1, 1'b0); add(2, 1, 1'b0); add(3, 1, 1'b0); add(0, 2, 1'b0);
    exp_out(0, 1); exp_out(1, 1); exp_out(2, 1); exp_out(3, 1); exp_out(0, 2);
    run_until_empty("t2");

    // 3: port 2 errors twice then clean, ports 1 and 3 competing
    do_reset();
    add(1, 0, 1'b0); exp_out(1, 0);  // move rr_ptr to 2
    run_until_empty("t3a");
    add(2, 1, 1'b1); add(2, 2, 1'b1); add(2, 3, 1'b0);
    add(1, 4, 1'b0); add(3, 4, 1'b0);
    exp_nack(2, 0); exp_nack(2, 0); exp_out(2, 3); exp_out(3, 4); exp_out(1, 4);
    run_until_empty("t3");
    chk("t3_err_cnt2", err_cnt[2*CW +: CW], exp_two);

    // 4: port 1 errors MAX_RETRY times -> drop, next grant port 2, retry count cleared
    do_reset();
    add(0, 0, 1'b0); exp_out(0, 0);  // move rr_ptr to 1
    run_until_empty("t4a");
    add(1, 1, 1'b1); add(1, 2, 1'b1); add(1, 3, 1'b1); add(1, 5, 1'b0);
    add(2, 1, 1'b0);
    exp_nack(1, 0); exp_nack(1, 0); exp_nack(1, 1); exp_out(2, 1); exp_out(1, 5);
    run_until_empty("t4");

    // 5: downstream stalls for 5 cycles in SEND
    do_reset();
    out_ready = 1'b0;
    add(0, 7, 1'b0); add(1, 7, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_valid", out_valid, 1);
      chk("t5_src", out_src, 0);
      chk("t5_data", out_data, dv(0, 7));
      chk("t5_in_ready", in_ready, 0);
      step();
    end
    exp_out(0, 7); exp_out(1, 7);
    out_ready = 1'b1;
    run_until_empty("t5");

    // 6: five errors on port 0 saturate a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) add(0, i, 1'b1);
    add(0, 9, 1'b0);
    exp_nack(0, 0); exp_nack(0, 0); exp_nack(0, 1); exp_nack(0, 0); exp_nack(0, 0);
    exp_out(0, 9);
    run_until_empty("t6");
    chk("t6_err_cnt0", err_cnt[0 +: CW], exp_sat);
    chk("t6_err_cnt_rest", err_cnt[NP*CW-1:CW], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
